// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full adder processes operands LSB first, one bit per clock,
// behind a valid/ready handshake on both the operand and the result side.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             c_out_q;
    logic             in_ready_q;
    logic [1:0]       fa;

    // Returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic [1:0] h0;
        logic [1:0] h1;
        h0 = half_add(x, y);
        h1 = half_add(h0[0], ci);
        return {h0[1] | h1[1], h1[0]};
    endfunction

    assign fa = full_add(a_sh[0], b_sh[0], carry);

    // Gate with rst_n so the block never advertises readiness while reset is held.
    assign in_ready = in_ready_q & rst_n;
    assign sum      = sum_sh;
    assign c_out    = c_out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
            out_valid  <= 1'b0;
            cnt        <= '0;
            carry      <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            c_out_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh       <= a;
                        b_sh       <= b;
                        carry      <= c_in;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {fa[0], sum_sh[WIDTH-1:1]};
                    carry  <= fa[1];
                    if (cnt == CNT_LAST) begin
                        c_out_q   <= fa[1];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        in_ready_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    out_valid  <= 1'b0;
                    in_ready_q <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboarded bench for serial_add_ctrl (WIDTH=8): latency, carries, backpressure,
// mid-operation reset, throughput and a random soak.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_count = 0;
    int acc_cyc = 0;
    logic [WIDTH:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out)
    );

    always #5 clk = ~clk;

    // Scoreboard: expected {c_out,sum} pushed on acceptance, popped on result handshake.
    always @(posedge clk) begin
        logic [WIDTH:0] exp_v;
        cyc = cyc + 1;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: result %h with nothing outstanding", {c_out, sum});
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({c_out, sum} !== exp_v) begin
                        miscompares++;
                        $display("FAIL sb_result: got %h want %h", {c_out, sum}, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in});
                acc_count++;
                acc_cyc = cyc;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic accept_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        int n0;
        n0 = acc_count;
        a = av; b = bv; c_in = cv; in_valid = 1'b1;
        for (int i = 0; i < 50 && acc_count == n0; i++) @(negedge clk);
        in_valid = 1'b0;
        if (acc_count == n0) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: got no acceptance want acceptance of %h+%h+%b", av, bv, cv);
        end
    endtask

    task automatic wait_valid(output int seen);
        seen = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) begin
                seen = cyc;
                break;
            end
            @(negedge clk);
        end
        if (seen < 0) begin
            vectors++; miscompares++;
            $display("FAIL valid_timeout: got out_valid=%b want 1 within 40 cycles", out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++;
        if ({c_out, sum} !== 9'h000) begin miscompares++; $display("FAIL reset_result: got %h want 000", {c_out, sum}); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    // Leaves the 0x0F+0x01 result pending for the backpressure test.
    task automatic test_basic();
        int t;
        int vc;
        out_ready = 1'b0;
        accept_op(8'h0F, 8'h01, 1'b0);
        t = acc_cyc - 1;
        wait_valid(vc);
        vectors++;
        if (vc !== t + WIDTH + 1) begin miscompares++; $display("FAIL basic_latency: got cycle %0d want %0d", vc, t + WIDTH + 1); end
        vectors++;
        if ({c_out, sum} !== 9'h010) begin miscompares++; $display("FAIL basic_result: got %h want 010", {c_out, sum}); end
    endtask

    task automatic test_backpressure();
        int n0;
        n0 = acc_count;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
            in_valid = (i % 2 == 0);
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || {c_out, sum} !== 9'h010) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid=%b result=%h want valid=1 result=010", i, out_valid, {c_out, sum});
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (acc_count !== n0) begin miscompares++; $display("FAIL bp_no_accept: got %0d acceptances want 0", acc_count - n0); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_carry();
        logic [WIDTH-1:0] av[2] = '{8'hFF, 8'hFF};
        logic [WIDTH-1:0] bv[2] = '{8'h01, 8'hFF};
        logic             cv[2] = '{1'b0, 1'b1};
        logic [WIDTH:0]   ev[2] = '{9'h100, 9'h1FF};
        int vc;
        for (int i = 0; i < 2; i++) begin
            out_ready = 1'b0;
            accept_op(av[i], bv[i], cv[i]);
            wait_valid(vc);
            vectors++;
            if ({c_out, sum} !== ev[i]) begin miscompares++; $display("FAIL carry[%0d]: got %h want %h", i, {c_out, sum}, ev[i]); end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int vc;
        int stray;
        out_ready = 1'b1;
        accept_op(8'hAA, 8'h55, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_state: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        vectors++;
        if (stray != 0) begin miscompares++; $display("FAIL midreset_abort: got %0d out_valid cycles want 0", stray); end
        accept_op(8'h03, 8'h05, 1'b0);
        wait_valid(vc);
        vectors++;
        if ({c_out, sum} !== 9'h008) begin miscompares++; $display("FAIL midreset_next: got %h want 008", {c_out, sum}); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int acc_at[5];
        int n;
        int last;
        n = 0;
        last = acc_count;
        out_ready = 1'b1;
        a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
        in_valid = 1'b1;
        for (int i = 0; i < 80 && n < 5; i++) begin
            @(negedge clk);
            if (acc_count != last) begin
                acc_at[n] = acc_cyc;
                n++;
                last = acc_count;
                a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (n != 5) begin miscompares++; $display("FAIL b2b_count: got %0d acceptances want 5", n); end
        for (int i = 1; i < n; i++) begin
            vectors++;
            if (acc_at[i] - acc_at[i-1] != WIDTH + 2) begin
                miscompares++;
                $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, acc_at[i] - acc_at[i-1], WIDTH + 2);
            end
        end
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_drain: got %0d outstanding want 0", exp_q.size()); end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int n0;
        int i;
        n0 = acc_count;
        i = 0;
        while (i < 40000 && ((acc_count - n0) < 1000 || exp_q.size() != 0)) begin
            a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
            in_valid = ((acc_count - n0) < 1000) && ($urandom_range(3) != 0);
            out_ready = 1'($urandom_range(1));
            @(negedge clk);
            i++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if ((acc_count - n0) != 1000 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL random_complete: got %0d accepted, %0d outstanding want 1000, 0", acc_count - n0, exp_q.size());
        end
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_carry();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits. Legal range is 2..32.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand request.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: first operand.
REQ-008 The block SHALL have port b, input, WIDTH bits: second operand.
REQ-009 The block SHALL have port c_in, input, 1 bit: carry into bit 0.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result bits, equal to (a+b+c_in) mod 2^WIDTH.
REQ-013 The block SHALL have port c_out, output, 1 bit: carry out of bit WIDTH-1.

Function
REQ-014 The block SHALL add bit-serially, one bit per clock, LSB first, through exactly one shared 1-bit full adder. That full adder is two half adders (XOR/AND) plus an OR for the carry.
REQ-015 The FSM SHALL have states IDLE, ADD and DONE; any unreachable encoding SHALL go to IDLE on the next edge.
REQ-016 In IDLE, in_ready=1 (when rst_n=1) and out_valid=0; in ADD and DONE, in_ready=0.
REQ-017 IDLE->ADD SHALL occur on an edge with in_valid&&in_ready. On that edge: a and b load into shift registers, the carry register loads c_in, and the bit counter clears to 0.
REQ-018 Each ADD cycle SHALL apply the following on the edge:
- take bit = a_sh[0]^b_sh[0]^carry;
- set carry <= majority(a_sh[0], b_sh[0], carry);
- shift a_sh and b_sh right by 1;
- shift bit into the MSB of the sum register, which shifts right;
- increment the counter.
REQ-019 ADD->DONE SHALL occur on the edge where counter==WIDTH-1, so ADD lasts exactly WIDTH cycles.
REQ-020 If acceptance occurs on the edge ending cycle t, out_valid SHALL first be 1 in cycle t+WIDTH+1.
REQ-021 In DONE, out_valid=1, and sum and c_out SHALL hold stable until out_valid&&out_ready. On that edge the state goes DONE->IDLE.
REQ-022 The minimum spacing between acceptances SHALL be WIDTH+2 cycles; the block SHALL never accept new operands while busy or holding a result.
REQ-023 in_valid SHALL be ignored while in_ready=0, and changes on a, b or c_in after acceptance SHALL NOT affect the result in progress.
REQ-024 sum and c_out SHALL retain the last completed result in IDLE; their values are defined only while out_valid=1.
REQ-025 The counter width SHALL be clog2(WIDTH), and it SHALL NOT wrap during a legal operation.

Reset
REQ-026 On any edge with rst_n=0, the following SHALL hold regardless of state, including mid-ADD or in DONE:
- state SHALL go to IDLE, and out_valid SHALL be 0 on the next cycle;
- the counter, carry, shift registers, sum and c_out SHALL clear to 0.
REQ-027 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after rst_n returns to 1.
REQ-028 An operation aborted by reset SHALL never produce out_valid.

Verification (WIDTH=8)
REQ-029 The bench SHALL check a=8'h0F, b=8'h01, c_in=0 accepted at cycle t -> out_valid first at t+9, sum=8'h10, c_out=0.
REQ-030 The bench SHALL check a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1; and a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1.
REQ-031 The bench SHALL check backpressure as follows:
- stimulus: result 8'h10 is pending; hold out_ready=0 for 5 cycles while pulsing in_valid with new operands;
- response: sum and c_out are stable, in_ready=0 and no acceptance occurs;
- then raise out_ready: the next cycle is IDLE with in_ready=1.
REQ-032 The bench SHALL check reset mid-operation: rst_n=0 for one edge during the 4th ADD cycle -> next cycle out_valid=0 and in_ready=1. A following a=8'h03, b=8'h05, c_in=0 -> sum=8'h08, c_out=0.
REQ-033 The bench SHALL check throughput: with in_valid held high and out_ready held high, successive acceptances are exactly 10 cycles apart.
REQ-034 The bench SHALL run 1000 random a, b, c_in with random out_ready stalls, and {c_out,sum} SHALL equal a+b+c_in for every transaction.
